// File: rtl/cnn_pkg.sv
// Shared parameters and types for the convolution-layer weight path.
package cnn_pkg;

    localparam int DATA_WIDTH       = 16;
    localparam int KERNEL_SIZE_MAX  = 3;
    localparam int PARA_KERNEL      = 2;
    localparam int DEPTH_MAX        = 8;
    localparam int KERNEL_NUM_WIDTH = 8;

    // One bank word carries one slice of every kernel in a group.
    localparam int W  = KERNEL_SIZE_MAX * KERNEL_SIZE_MAX * PARA_KERNEL * DATA_WIDTH;
    localparam int SW = $clog2(DEPTH_MAX) + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_RUN,
        ST_WAIT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/weight_bank.sv
// One weight bank: synchronous write, registered read, contents not reset.
module weight_bank #(
    parameter int WIDTH = 288,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port and read-data register share the clock.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/weight_pingpong_ctrl.sv
// Ping-pong weight store: the host fills the shadow bank with group g+1
// while the PE array reads group g from the active bank.
//
// Host handshake: upd_req/upd_group is a level request. While upd_req=1 each
// wr_valid cycle writes one slice (no backpressure, always accepted when the
// address is in range); a wr_done pulse closes the load and drops upd_req on
// the following edge. Compute side: grp_ready is a level meaning the active
// bank is valid; one grp_done pulse while grp_ready=1 retires that group.
module weight_pingpong_ctrl #(
    parameter int DATA_WIDTH       = cnn_pkg::DATA_WIDTH,
    parameter int KERNEL_SIZE_MAX  = cnn_pkg::KERNEL_SIZE_MAX,
    parameter int PARA_KERNEL      = cnn_pkg::PARA_KERNEL,
    parameter int DEPTH_MAX        = cnn_pkg::DEPTH_MAX,
    parameter int KERNEL_NUM_WIDTH = cnn_pkg::KERNEL_NUM_WIDTH,
    localparam int W  = KERNEL_SIZE_MAX * KERNEL_SIZE_MAX * PARA_KERNEL * DATA_WIDTH,
    localparam int SW = $clog2(DEPTH_MAX) + 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cfg_valid,
    input  logic [SW-1:0]               cfg_fm_depth,
    input  logic [KERNEL_NUM_WIDTH-1:0] cfg_kernel_num,
    output logic                        upd_req,
    output logic [KERNEL_NUM_WIDTH-1:0] upd_group,
    input  logic                        wr_valid,
    input  logic [SW-2:0]               wr_addr,
    input  logic [W-1:0]                wr_data,
    input  logic                        wr_done,
    input  logic [SW-2:0]               rd_slice,
    output logic [W-1:0]                rd_data,
    output logic                        grp_ready,
    output logic [KERNEL_NUM_WIDTH-1:0] grp_idx,
    input  logic                        grp_done,
    output logic                        layer_done,
    output logic                        err_addr
);

    import cnn_pkg::*;

    localparam int KNW = KERNEL_NUM_WIDTH;

    state_t        state;
    logic [1:0]    full;
    logic          act_bank;
    logic [SW-1:0] fm_depth;
    logic [KNW:0]  num_groups;

    logic          tgt_bank;
    logic          wr_ok;
    logic          wr_done_eff;
    logic          shadow_full;
    logic          last_grp;
    logic          do_swap;
    logic [KNW:0]  idx_p1;
    logic [KNW:0]  idx_p2;
    logic [KNW:0]  kn_round;
    logic [KNW:0]  ng_calc;

    logic [W-1:0]  q0;
    logic [W-1:0]  q1;
    logic          rd_sel;
    logic          rd_zero;

    // Write target, group bookkeeping and swap decision.
    always_comb begin
        tgt_bank    = (state == ST_FILL) ? 1'b0 : ~act_bank;
        wr_ok       = wr_valid && upd_req && ({1'b0, wr_addr} < fm_depth);
        wr_done_eff = wr_done && upd_req;
        shadow_full = full[~act_bank] || wr_done_eff;
        idx_p1      = {1'b0, grp_idx} + (KNW+1)'(1);
        idx_p2      = {1'b0, grp_idx} + (KNW+1)'(2);
        last_grp    = (idx_p1 == num_groups);
        kn_round    = {1'b0, cfg_kernel_num} + (KNW+1)'(PARA_KERNEL - 1);
        ng_calc     = kn_round / (KNW+1)'(PARA_KERNEL);
        do_swap     = ((state == ST_RUN) && grp_done && !last_grp && shadow_full) ||
                      ((state == ST_WAIT) && wr_done_eff);
    end

    // Control FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            full       <= 2'b00;
            act_bank   <= 1'b0;
            fm_depth   <= '0;
            num_groups <= '0;
            upd_req    <= 1'b0;
            upd_group  <= '0;
            grp_ready  <= 1'b0;
            grp_idx    <= '0;
            layer_done <= 1'b0;
            err_addr   <= 1'b0;
        end else begin
            layer_done <= 1'b0;
            if ((state == ST_IDLE) && cfg_valid) begin
                err_addr <= 1'b0;
            end
            if (wr_valid && !wr_ok) begin
                err_addr <= 1'b1;
            end
            // A completed load marks its bank full; the write in the same
            // cycle has already been accepted by the bank.
            if (wr_done_eff) begin
                full[tgt_bank] <= 1'b1;
                upd_req        <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (cfg_valid) begin
                        fm_depth   <= cfg_fm_depth;
                        num_groups <= ng_calc;
                        grp_idx    <= '0;
                        if (cfg_kernel_num == '0) begin
                            state      <= ST_DONE;
                            layer_done <= 1'b1;
                        end else begin
                            state     <= ST_FILL;
                            upd_req   <= 1'b1;
                            upd_group <= '0;
                        end
                    end
                end
                ST_FILL: begin
                    if (wr_done_eff) begin
                        act_bank  <= 1'b0;
                        grp_ready <= 1'b1;
                        grp_idx   <= '0;
                        state     <= ST_RUN;
                        if (num_groups > (KNW+1)'(1)) begin
                            upd_req   <= 1'b1;
                            upd_group <= (KNW)'(1);
                        end
                    end
                end
                ST_RUN: begin
                    if (grp_done) begin
                        if (last_grp) begin
                            state      <= ST_DONE;
                            layer_done <= 1'b1;
                            grp_ready  <= 1'b0;
                        end else if (!shadow_full) begin
                            grp_ready <= 1'b0;
                            state     <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wr_done_eff) begin
                        grp_ready <= 1'b1;
                        state     <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    full      <= 2'b00;
                    grp_ready <= 1'b0;
                    upd_req   <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
            // Swap after the bookkeeping above so a new request overrides
            // the upd_req clear from a same-cycle wr_done.
            if (do_swap) begin
                act_bank       <= ~act_bank;
                full[act_bank] <= 1'b0;
                grp_idx        <= idx_p1[KNW-1:0];
                if (idx_p2 < num_groups) begin
                    upd_req   <= 1'b1;
                    upd_group <= idx_p2[KNW-1:0];
                end
            end
        end
    end

    weight_bank #(.WIDTH(W), .DEPTH(DEPTH_MAX), .AW(SW-1)) u_bank0 (
        .clk   (clk),
        .we    (wr_ok && (tgt_bank == 1'b0)),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (rd_slice),
        .rdata (q0)
    );

    weight_bank #(.WIDTH(W), .DEPTH(DEPTH_MAX), .AW(SW-1)) u_bank1 (
        .clk   (clk),
        .we    (wr_ok && (tgt_bank == 1'b1)),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (rd_slice),
        .rdata (q1)
    );

    // Capture bank select and range check alongside the registered bank read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_sel  <= 1'b0;
            rd_zero <= 1'b1;
        end else begin
            rd_sel  <= act_bank;
            rd_zero <= !({1'b0, rd_slice} < fm_depth);
        end
    end

    assign rd_data = rd_zero ? '0 : (rd_sel ? q1 : q0);

endmodule

// File: tb/tb_weight_pingpong_ctrl.sv
// Self-checking bench for weight_pingpong_ctrl.
module tb_weight_pingpong_ctrl;
  import cnn_pkg::*;

  localparam int KNW = KERNEL_NUM_WIDTH;
  localparam int AW  = SW - 1;

  logic           clk;
  logic           rst;
  logic           cfg_valid;
  logic [SW-1:0]  cfg_fm_depth;
  logic [KNW-1:0] cfg_kernel_num;
  logic           upd_req;
  logic [KNW-1:0] upd_group;
  logic           wr_valid;
  logic [AW-1:0]  wr_addr;
  logic [W-1:0]   wr_data;
  logic           wr_done;
  logic [AW-1:0]  rd_slice;
  logic [W-1:0]   rd_data;
  logic           grp_ready;
  logic [KNW-1:0] grp_idx;
  logic           grp_done;
  logic           layer_done;
  logic           err_addr;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  weight_pingpong_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_valid      (cfg_valid),
    .cfg_fm_depth   (cfg_fm_depth),
    .cfg_kernel_num (cfg_kernel_num),
    .upd_req        (upd_req),
    .upd_group      (upd_group),
    .wr_valid       (wr_valid),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .wr_done        (wr_done),
    .rd_slice       (rd_slice),
    .rd_data        (rd_data),
    .grp_ready      (grp_ready),
    .grp_idx        (grp_idx),
    .grp_done       (grp_done),
    .layer_done     (layer_done),
    .err_addr       (err_addr)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int ld_count = 0;
  int cur_depth = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] model_mem [0:3][0:7];
  logic         rd_active;
  logic [W-1:0] rd_exp;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < W / 16; i++) v[i*16 +: 16] = 16'($urandom_range(0, 16'hFFFF));
    return v;
  endfunction

  // scoreboard: expected read words queued at the read edge, compared after it
  always @(posedge clk) begin
    if (rd_active) exp_q.push_back(rd_exp);
    #1;
    if (exp_q.size() > 0) check("rd_data", rd_data, exp_q.pop_front());
  end

  // layer_done pulse counter
  always @(posedge clk) begin
    #1;
    if (layer_done) ld_count++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input int depth, input int kn);
    cfg_valid      = 1'b1;
    cfg_fm_depth   = SW'(depth);
    cfg_kernel_num = KNW'(kn);
    cur_depth      = depth;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic host_write(input int slice, input logic [W-1:0] data);
    wr_valid = 1'b1;
    wr_addr  = AW'(slice);
    wr_data  = data;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic write_group(input int g);
    for (int s = 0; s < cur_depth; s++) begin
      model_mem[g][s] = rand_word();
      host_write(s, model_mem[g][s]);
    end
  endtask

  task automatic pulse_wr_done();
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
  endtask

  task automatic pulse_grp_done();
    grp_done = 1'b1;
    tick();
    grp_done = 1'b0;
  endtask

  task automatic load_group(input int g);
    write_group(g);
    pulse_wr_done();
  endtask

  // reads every valid slice plus one past the end, which must read as zero
  task automatic read_group(input int g);
    for (int s = 0; s <= cur_depth; s++) begin
      rd_slice  = AW'(s);
      rd_exp    = (s < cur_depth) ? model_mem[g][s] : '0;
      rd_active = 1'b1;
      tick();
    end
    rd_active = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    cfg_valid = 1'b0; cfg_fm_depth = '0; cfg_kernel_num = '0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_done = 1'b0;
    rd_slice = '0; grp_done = 1'b0; rd_active = 1'b0; rd_exp = '0;
    tick();
    tick();
    check("rst_upd_req", upd_req, 0);
    check("rst_upd_group", upd_group, 0);
    check("rst_grp_ready", grp_ready, 0);
    check("rst_grp_idx", grp_idx, 0);
    check("rst_layer_done", layer_done, 0);
    check("rst_err_addr", err_addr, 0);
    check("rst_rd_data", rd_data, 0);
    rst = 1'b0;
    tick();

    // basic 3-group layer, host answers every request at once
    ld_count = 0;
    do_cfg(2, 6);
    check("t1_upd_req0", upd_req, 1);
    check("t1_upd_group0", upd_group, 0);
    check("t1_ready_low", grp_ready, 0);
    load_group(0);
    check("t1_ready0", grp_ready, 1);
    check("t1_idx0", grp_idx, 0);
    check("t1_upd_group1", upd_group, 1);
    check("t1_upd_req1", upd_req, 1);
    for (int g = 0; g < 2; g++) begin
      load_group(g + 1);
      check("t1_req_cleared", upd_req, 0);
      read_group(g);
      repeat (10 - 2 * (cur_depth + 1)) tick();
      pulse_grp_done();
      check("t1_ready_no_gap", grp_ready, 1);
      check("t1_idx_step", grp_idx, g + 1);
      check("t1_upd_req_next", upd_req, (g == 0) ? 1 : 0);
      if (g == 0) check("t1_upd_group2", upd_group, 2);
    end
    read_group(2);
    pulse_grp_done();
    check("t1_layer_done", layer_done, 1);
    check("t1_ready_end", grp_ready, 0);
    tick();
    check("t1_layer_done_pulse", layer_done, 0);
    check("t1_ld_count", ld_count, 1);

    // slow host: group 1 arrives long after grp_done
    do_cfg(2, 6);
    load_group(0);
    check("t2_ready0", grp_ready, 1);
    pulse_grp_done();
    check("t2_wait_ready", grp_ready, 0);
    check("t2_wait_req", upd_req, 1);
    check("t2_wait_group", upd_group, 1);
    repeat (20) tick();
    check("t2_still_wait", grp_ready, 0);
    load_group(1);
    check("t2_ready1", grp_ready, 1);
    check("t2_idx1", grp_idx, 1);
    check("t2_upd_group2", upd_group, 2);
    check("t2_upd_req2", upd_req, 1);
    read_group(1);

    // grp_done and wr_done in the same cycle
    write_group(2);
    wr_done  = 1'b1;
    grp_done = 1'b1;
    tick();
    wr_done  = 1'b0;
    grp_done = 1'b0;
    check("t3_ready_kept", grp_ready, 1);
    check("t3_idx2", grp_idx, 2);
    check("t3_no_req", upd_req, 0);
    read_group(2);
    pulse_grp_done();
    check("t3_layer_done", layer_done, 1);
    tick();

    // illegal writes
    host_write(0, rand_word());
    check("t4_err_idle_write", err_addr, 1);
    do_cfg(2, 4);
    check("t4_err_cleared", err_addr, 0);
    write_group(0);
    host_write(2, rand_word());
    check("t4_err_range", err_addr, 1);
    pulse_wr_done();
    check("t4_ready0", grp_ready, 1);
    load_group(1);
    read_group(0);
    pulse_grp_done();
    check("t4_idx1", grp_idx, 1);
    check("t4_no_req", upd_req, 0);
    host_write(0, rand_word());
    read_group(1);
    pulse_grp_done();
    check("t4_layer_done", layer_done, 1);
    tick();
    check("t4_err_sticky", err_addr, 1);

    // kernel_num = 0
    ld_count = 0;
    do_cfg(2, 0);
    check("t5_no_req", upd_req, 0);
    check("t5_layer_done", layer_done, 1);
    check("t5_err_cleared", err_addr, 0);
    tick();
    check("t5_pulse_end", layer_done, 0);
    check("t5_no_req_after", upd_req, 0);
    check("t5_ld_count", ld_count, 1);

    // kernel_num = 1, depth 3, with an out-of-range write during the fill
    do_cfg(3, 1);
    check("t6_upd_req", upd_req, 1);
    check("t6_upd_group", upd_group, 0);
    host_write(3, rand_word());
    check("t6_err_range", err_addr, 1);
    load_group(0);
    check("t6_ready", grp_ready, 1);
    check("t6_no_second_req", upd_req, 0);
    read_group(0);
    pulse_grp_done();
    check("t6_layer_done", layer_done, 1);
    check("t6_ready_end", grp_ready, 0);
    tick();

    // reset mid-layer with group 1 half written
    do_cfg(2, 6);
    load_group(0);
    check("t7_ready0", grp_ready, 1);
    host_write(0, rand_word());
    #3;
    rst = 1'b1;
    #1;
    check("t7_rst_upd_req", upd_req, 0);
    check("t7_rst_upd_group", upd_group, 0);
    check("t7_rst_ready", grp_ready, 0);
    check("t7_rst_layer_done", layer_done, 0);
    check("t7_rst_err", err_addr, 0);
    check("t7_rst_rd_data", rd_data, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    do_cfg(2, 6);
    check("t7_restart_req", upd_req, 1);
    check("t7_restart_group", upd_group, 0);
    check("t7_restart_ready", grp_ready, 0);
    load_group(0);
    check("t7_ready", grp_ready, 1);
    check("t7_idx", grp_idx, 0);
    read_group(0);
    tick();
    tick();
    check("sb_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
